// File: rtl/datapath_pkg.sv
// datapath_pkg: shared constants for the two-register bring-up datapath.
//   - ALU opcodes presented on the 'operation' input
//   - bit positions of the non-GPR bus-source strobes in encoder_input
package datapath_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b00000;

  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHIGH  = 18;
  localparam int SEL_ZLOW   = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int SEL_C      = 23;

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU with a double-width result.
//   a    in  WIDTH     operand A (Y register)
//   b    in  WIDTH     operand B (bus)
//   op   in  5         opcode (datapath_pkg OP_*)
//   AND  in  1         legacy AND select, honoured only when op is zero
//   c    out 2*WIDTH   result
// Build option: DATAPATH_DIV_EN enables the signed divider (op 01111);
// without it that opcode returns zero and no divider is built.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         op,
  input  logic               AND,
  output logic [2*WIDTH-1:0] c
);

  logic [4:0]         amt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] a_sx;
  logic [2*WIDTH-1:0] b_sx;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] ror_dbl;
  logic [2*WIDTH-1:0] rol_dbl;
  logic [WIDTH-1:0]   shra_res;

  assign amt  = b[4:0];
  assign sum  = a + b;
  assign diff = a - b;

  // Sign-extending both operands makes the low 2*WIDTH bits of an
  // unsigned product equal to the signed product.
  assign a_sx = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod = a_sx * b_sx;

  // Rotates taken from a doubled copy of A.
  assign ror_dbl  = {a, a} >> amt;
  assign rol_dbl  = {a, a} << amt;
  assign shra_res = $signed(a) >>> amt;

`ifdef DATAPATH_DIV_EN
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  always_comb begin
    quo = '0;
    rem = '0;
    if (b != '0) begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end
  end
`endif

  always_comb begin
    c = '0;
    case (op)
      OP_ADD:  c = {{WIDTH{sum[WIDTH-1]}}, sum};
      OP_SUB:  c = {{WIDTH{diff[WIDTH-1]}}, diff};
      OP_AND:  c = {{WIDTH{1'b0}}, a & b};
      OP_OR:   c = {{WIDTH{1'b0}}, a | b};
      OP_ROR:  c = {{WIDTH{1'b0}}, ror_dbl[WIDTH-1:0]};
      OP_ROL:  c = {{WIDTH{1'b0}}, rol_dbl[2*WIDTH-1:WIDTH]};
      OP_SHR:  c = {{WIDTH{1'b0}}, a >> amt};
      OP_SHRA: c = {{WIDTH{1'b0}}, shra_res};
      OP_SHL:  c = {{WIDTH{1'b0}}, a << amt};
      OP_MUL:  c = prod;
`ifdef DATAPATH_DIV_EN
      OP_DIV:  c = {rem, quo};
`endif
      OP_NEG:  c = {{WIDTH{1'b0}}, -b};
      OP_NOT:  c = {{WIDTH{1'b0}}, ~b};
      OP_NOP:  if (AND) c = {{WIDTH{1'b0}}, a & b};
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/datapath_two_reg.sv
// datapath_two_reg: single-bus datapath with R2/R6, PC, IR, Y, MAR, MDR,
// HI, LO and the ZHigh/ZLow result pair.
//   Clock              in  system clock, rising edge
//   clear              in  synchronous active-high reset, beats all strobes
//   *out strobes       in  bus-source selects (highest encoder bit wins)
//   *in strobes        in  register load enables
//   IncPC              in  PC increment when PCin is low
//   Read               in  MDR loads Mdatain instead of the bus
//   AND                in  legacy AND select for opcode 00000
//   Mdatain            in  memory data into MDR
//   operation          in  ALU opcode
//   encoder_input      out concatenated source strobes
// Build option: DATAPATH_DIV_EN enables the ALU divider.
module datapath_two_reg
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             PCout, Zlowout, Zhighout, MDRout, R2out, R6out,
  input  logic             LOout, HIout, Cout, InPortout,
  input  logic             R0out, R1out, R3out, R4out, R5out, R7out,
  input  logic             R8out, R9out, R10out, R11out, R12out, R13out,
  input  logic             R14out, R15out,
  input  logic             MARin, MDRin, PCin, IRin, Yin, Zlowin, Zhighin,
  input  logic             R2in, R6in, LOin, HIin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             AND,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       operation,
  output logic [31:0]      encoder_input
);

  logic [WIDTH-1:0]   pc_q, ir_q, y_q, mar_q, mdr_q, hi_q, lo_q;
  logic [WIDTH-1:0]   zhigh_q, zlow_q, r2_q, r6_q;
  logic [WIDTH-1:0]   bus;
  logic [4:0]         sel;
  logic [2*WIDTH-1:0] alu_c;
  logic [31:0]        enc;

  always_comb begin
    enc = '0;
    enc[15:0] = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    enc[SEL_HI]     = HIout;
    enc[SEL_LO]     = LOout;
    enc[SEL_ZHIGH]  = Zhighout;
    enc[SEL_ZLOW]   = Zlowout;
    enc[SEL_PC]     = PCout;
    enc[SEL_MDR]    = MDRout;
    enc[SEL_INPORT] = InPortout;
    enc[SEL_C]      = Cout;
  end

  assign encoder_input = enc;

  // Highest set bit wins; with nothing set sel is 0 (R0), which drives 0.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 32; i++) begin
      if (enc[i]) sel = 5'(i);
    end
  end

  // Absent sources (R0/R1/R3-R5/R7-R15, InPort, C) fall to the default.
  always_comb begin
    bus = '0;
    case (int'(sel))
      2:         bus = r2_q;
      6:         bus = r6_q;
      SEL_HI:    bus = hi_q;
      SEL_LO:    bus = lo_q;
      SEL_ZHIGH: bus = zhigh_q;
      SEL_ZLOW:  bus = zlow_q;
      SEL_PC:    bus = pc_q;
      SEL_MDR:   bus = mdr_q;
      default:   bus = '0;
    endcase
  end

  datapath_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (y_q),
    .b   (bus),
    .op  (operation),
    .AND (AND),
    .c   (alu_c)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      pc_q    <= '0;
      ir_q    <= '0;
      y_q     <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zhigh_q <= '0;
      zlow_q  <= '0;
      r2_q    <= '0;
      r6_q    <= '0;
    end else begin
      if (R2in)  r2_q  <= bus;
      if (R6in)  r6_q  <= bus;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (Yin)   y_q   <= bus;
      if (MARin) mar_q <= bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (PCin)       pc_q <= bus;
      else if (IncPC) pc_q <= pc_q + WIDTH'(1);
      if (Zlowin) begin
        zhigh_q <= alu_c[2*WIDTH-1:WIDTH];
        zlow_q  <= alu_c[WIDTH-1:0];
      end else if (Zhighin) begin
        zhigh_q <= alu_c[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_datapath_two_reg.sv
module tb_datapath_two_reg;

  logic        Clock, clear;
  logic        PCout, Zlowout, Zhighout, MDRout, R2out, R6out, LOout, HIout, Cout, InPortout;
  logic        R0out, R1out, R3out, R4out, R5out, R7out, R8out, R9out, R10out;
  logic        R11out, R12out, R13out, R14out, R15out;
  logic        MARin, MDRin, PCin, IRin, Yin, Zlowin, Zhighin, R2in, R6in, LOin, HIin;
  logic        IncPC, Read, AND;
  logic [31:0] Mdatain;
  logic [4:0]  operation;
  logic [31:0] encoder_input;

  int passed = 0;
  int total  = 0;

`ifdef DATAPATH_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  datapath_two_reg dut (
    .Clock(Clock), .clear(clear),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .R2out(R2out), .R6out(R6out), .LOout(LOout), .HIout(HIout), .Cout(Cout),
    .InPortout(InPortout),
    .R0out(R0out), .R1out(R1out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
    .R7out(R7out), .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
    .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
    .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .R2in(R2in), .R6in(R6in), .LOin(LOin),
    .HIin(HIin), .IncPC(IncPC), .Read(Read), .AND(AND), .Mdatain(Mdatain),
    .operation(operation), .encoder_input(encoder_input)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] y;
    logic [31:0] b;
    logic [4:0]  op;
    logic        andb;
    logic [31:0] zh;
    logic [31:0] zl;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic set_all(input logic v);
    {PCout, Zlowout, Zhighout, MDRout, R2out, R6out, LOout, HIout, Cout, InPortout} = {10{v}};
    {R0out, R1out, R3out, R4out, R5out, R7out, R8out, R9out, R10out} = {9{v}};
    {R11out, R12out, R13out, R14out, R15out} = {5{v}};
    {MARin, MDRin, PCin, IRin, Yin, Zlowin, Zhighin, R2in, R6in, LOin, HIin} = {11{v}};
    {IncPC, Read, AND} = {3{v}};
  endtask

  task automatic clr;
    set_all(1'b0);
    operation = 5'b0;
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clr;
    Read = 1; MDRin = 1; Mdatain = v;
    tick;
    clr;
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1;
    tick;
    clr;
  endtask

  initial begin
    vecs[0]  = '{32'd5,        32'd7,        5'b00011, 1'b0, 32'h0,        32'd12};
    vecs[1]  = '{32'h7FFFFFFF, 32'd1,        5'b00011, 1'b0, 32'hFFFFFFFF, 32'h80000000};
    vecs[2]  = '{32'd3,        32'd5,        5'b00100, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{32'd10,       32'd3,        5'b00100, 1'b0, 32'h0,        32'd7};
    vecs[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, 5'b00101, 1'b0, 32'h0,        32'hF000F000};
    vecs[5]  = '{32'hF0F0F0F0, 32'h0F0F0000, 5'b00110, 1'b0, 32'h0,        32'hFFFFF0F0};
    vecs[6]  = '{32'h00000001, 32'd1,        5'b00111, 1'b0, 32'h0,        32'h80000000};
    vecs[7]  = '{32'h80000001, 32'd4,        5'b01000, 1'b0, 32'h0,        32'h00000018};
    vecs[8]  = '{32'h80000000, 32'd4,        5'b01001, 1'b0, 32'h0,        32'h08000000};
    vecs[9]  = '{32'h80000000, 32'd4,        5'b01010, 1'b0, 32'h0,        32'hF8000000};
    vecs[10] = '{32'h00000001, 32'd31,       5'b01011, 1'b0, 32'h0,        32'h80000000};
    vecs[11] = '{32'h00000001, 32'h24,       5'b01011, 1'b0, 32'h0,        32'h00000010};
    vecs[12] = '{32'hFFFFFFFE, 32'd3,        5'b10000, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[13] = '{32'h00010000, 32'h00010000, 5'b10000, 1'b0, 32'h1,        32'h0};
    vecs[14] = '{32'd7,        32'd2,        5'b01111, 1'b0, DIV_ON ? 32'd1 : 32'd0, DIV_ON ? 32'd3 : 32'd0};
    vecs[15] = '{32'd7,        32'd0,        5'b01111, 1'b0, 32'h0,        32'h0};
    vecs[16] = '{32'hFFFFFFF9, 32'd2,        5'b01111, 1'b0, DIV_ON ? 32'hFFFFFFFF : 32'd0, DIV_ON ? 32'hFFFFFFFD : 32'd0};
    vecs[17] = '{32'd0,        32'd5,        5'b10001, 1'b0, 32'h0,        32'hFFFFFFFB};
    vecs[18] = '{32'd0,        32'd0,        5'b10010, 1'b0, 32'h0,        32'hFFFFFFFF};
    vecs[19] = '{32'h000000F0, 32'h3C,       5'b00000, 1'b1, 32'h0,        32'h00000030};
    vecs[20] = '{32'h000000F0, 32'h3C,       5'b00000, 1'b0, 32'h0,        32'h0};
    vecs[21] = '{32'h000000F0, 32'h3C,       5'b11111, 1'b1, 32'h0,        32'h0};
    vecs[22] = '{32'h000000F0, 32'h3C,       5'b01100, 1'b0, 32'h0,        32'h0};
    vecs[23] = '{32'h12345678, 32'd0,        5'b00111, 1'b0, 32'h0,        32'h12345678};

    Mdatain = 32'hDEADBEEF;
    operation = 5'b10000;
    set_all(1'b1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    clr;
    #1;
    check("rst_pc",    dut.pc_q,    32'h0);
    check("rst_ir",    dut.ir_q,    32'h0);
    check("rst_y",     dut.y_q,     32'h0);
    check("rst_mar",   dut.mar_q,   32'h0);
    check("rst_mdr",   dut.mdr_q,   32'h0);
    check("rst_hi",    dut.hi_q,    32'h0);
    check("rst_lo",    dut.lo_q,    32'h0);
    check("rst_zhigh", dut.zhigh_q, 32'h0);
    check("rst_zlow",  dut.zlow_q,  32'h0);
    check("rst_r2",    dut.r2_q,    32'h0);
    check("rst_r6",    dut.r6_q,    32'h0);
    check("rst_bus",   dut.bus,     32'h0);
    check("rst_enc",   encoder_input, 32'h0);

    // MDR -> R2, MDR -> R6
    load_mdr(32'h22);
    MDRout = 1; R2in = 1; tick; clr;
    check("r2_load", dut.r2_q, 32'h22);
    load_mdr(32'h24);
    MDRout = 1; R6in = 1; tick; clr;
    check("r6_load", dut.r6_q, 32'h24);

    // Multiply R2*R6 into LO/HI
    R2out = 1; Yin = 1; tick; clr;
    R6out = 1; Zlowin = 1; operation = 5'b10000; tick; clr;
    Zlowout = 1; LOin = 1; tick; clr;
    Zhighout = 1; HIin = 1; tick; clr;
    check("mul_lo", dut.lo_q, 32'h4C8);
    check("mul_hi", dut.hi_q, 32'h0);
    HIout = 1; LOout = 1; #1;
    check("bus_lo_over_hi", dut.bus, 32'h4C8);
    clr;

    // ALU table
    for (int i = 0; i < NV; i++) begin
      load_y(vecs[i].y);
      load_mdr(vecs[i].b);
      MDRout = 1; Zlowin = 1; operation = vecs[i].op; AND = vecs[i].andb;
      tick; clr;
      check($sformatf("alu%0d_zhigh", i), dut.zhigh_q, vecs[i].zh);
      check($sformatf("alu%0d_zlow", i),  dut.zlow_q,  vecs[i].zl);
    end

    // Zhighin alone leaves ZLow intact: Y=-2, bus=3, mul then add
    load_y(32'hFFFFFFFE);
    load_mdr(32'd3);
    MDRout = 1; Zlowin = 1; operation = 5'b10000; tick; clr;
    load_mdr(32'd1);
    MDRout = 1; Zhighin = 1; operation = 5'b00011; tick; clr;
    check("zhi_only_zhigh", dut.zhigh_q, 32'hFFFFFFFF);
    check("zhi_only_zlow",  dut.zlow_q,  32'hFFFFFFFA);

    // Drive and load ZLow in the same cycle: Y=1, ZLow=5 -> ZLow=6
    load_y(32'd5);
    load_mdr(32'd0);
    MDRout = 1; Zlowin = 1; operation = 5'b00011; tick; clr;
    load_y(32'd1);
    Zlowout = 1; Zlowin = 1; operation = 5'b00011; tick; clr;
    check("z_self_update", dut.zlow_q, 32'd6);

    // PC wrap and PCin priority
    load_mdr(32'hFFFFFFFF);
    MDRout = 1; PCin = 1; tick; clr;
    check("pc_load", dut.pc_q, 32'hFFFFFFFF);
    IncPC = 1; tick; clr;
    check("pc_wrap", dut.pc_q, 32'h0);
    IncPC = 1; tick; clr;
    check("pc_inc", dut.pc_q, 32'h1);
    load_mdr(32'h10);
    MDRout = 1; PCin = 1; IncPC = 1; tick; clr;
    check("pc_pcin_wins", dut.pc_q, 32'h10);

    // Encoder priority
    load_mdr(32'hABCD0123);
    PCout = 1; MDRout = 1; #1;
    check("enc_pc_mdr", encoder_input, 32'h0030_0000);
    check("bus_mdr_wins", dut.bus, 32'hABCD0123);
    clr;
    R3out = 1; #1;
    check("enc_r3", encoder_input, 32'h0000_0008);
    check("bus_r3_zero", dut.bus, 32'h0);
    clr;
    R2out = 1; Cout = 1; #1;
    check("bus_c_over_r2", dut.bus, 32'h0);
    clr;
    R2out = 1; R6out = 1; #1;
    check("bus_r6_over_r2", dut.bus, 32'h24);
    clr;

    // MDR without Read loads the bus
    PCout = 1; MDRin = 1; Mdatain = 32'h55; tick; clr;
    check("mdr_from_bus", dut.mdr_q, 32'h10);

    // clear wins over strobes mid-run
    R2in = 1; MDRout = 1; clear = 1; tick; clear = 0; clr;
    check("clear_r2", dut.r2_q, 32'h0);
    check("clear_pc", dut.pc_q, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/datapath_two_reg.md
Name: datapath_two_reg

Overview:
- Reduced single-bus 32-bit CPU datapath for the multi-cycle processor bring-up.
- Contains only general registers R2 and R6, plus PC, IR, Y, MAR, MDR, HI, LO, a 64-bit Z pair and a combinational ALU.
- Every register transfer is driven externally by control strobes, one bus source per cycle, selected by a 32-to-5 encoder.
- Used to verify register-transfer sequences such as load, ALU op, and result to HI/LO.

Parameters:
- WIDTH, 32, datapath/bus width; the ALU result is 2*WIDTH.

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- PCout, Zlowout, Zhighout, MDRout, R2out, R6out, LOout, HIout, Cout, InPortout  in  1 each  bus-source strobes
- R0out, R1out, R3out, R4out, R5out, R7out..R15out  in  1 each  bus-source strobes for absent registers
- MARin, MDRin, PCin, IRin, Yin, Zlowin, Zhighin, R2in, R6in, LOin, HIin  in  1 each  register load enables
- IncPC  in  1  PC increment
- Read  in  1  MDR input select
- AND  in  1  legacy AND select
- Mdatain  in  32  memory data into MDR
- operation  in  5  ALU opcode
- encoder_input  out  32  concatenated source strobes, as presented to the encoder

Behaviour:
- Encoder input bit map: bits 0-15 = R0out..R15out; 16 HIout; 17 LOout; 18 Zhighout; 19 Zlowout; 20 PCout; 21 MDRout; 22 InPortout; 23 Cout; bits 24-31 = 0.
- Encoder output: the index of the highest set bit.
- Bus when no strobe is set: 0.
- Bus source values:
  - R2out, R6out, HIout, LOout, PCout and MDRout drive their register.
  - Zhighout drives ZHigh; Zlowout drives ZLow.
  - R0, R1, R3-R5, R7-R15, InPort and C drive 0 (not instantiated here).
- The bus is purely combinational; there is no bus latency.
- Register updates on the rising edge of Clock:
  - clear=1: every register goes to 0, including PC, IR, Y, MAR, MDR, HI, LO, ZHigh, ZLow, R2 and R6. clear has priority over all strobes.
  - R2, R6, HI, LO, IR, Y and MAR each load the bus when their "in" strobe is set.
  - MDR: when MDRin=1, loads Mdatain if Read=1, otherwise the bus.
  - PC: PCin=1 loads the bus. Otherwise IncPC=1 makes PC <= PC+1 (wraps from 0xFFFFFFFF to 0). PCin wins over IncPC.
  - Zlowin=1: ZHigh <= C[63:32] and ZLow <= C[31:0].
  - Zhighin=1 alone: ZHigh <= C[63:32] only.
- Simultaneous load and drive of the same register: the register takes the bus value present before the edge.
- ALU (combinational): A = Y, B = bus, C is 64 bits, opcode = operation.
  - 00011 add, 00100 sub: C = sign-extended 32-bit result.
  - 00101 and, 00110 or: C = {32'b0, result}.
  - 00111 ror, 01000 rol: rotate amount = B[4:0].
  - 01001 shr, 01010 shra, 01011 shl: shift amount = B[4:0].
  - 10000 mul: signed A*B, full 64 bits.
  - 01111 div: C = {A%B, A/B}, signed; divide by zero gives C = 0.
  - 10001 neg: C = {32'b0, -B}.
  - 10010 not: C = {32'b0, ~B}.
  - 00000 with AND=1: C = A&B.
  - All other codes: C = 0. AND is ignored when operation is nonzero.

Optional Feature:
- Macro DATAPATH_DIV_EN.
- Defined: opcode 01111 performs signed division as above.
- Undefined: 01111 yields C = 0, and no divider logic is synthesized.

Decomposition:
- Shared package datapath_pkg holds:
  - the ALU opcode localparams (OP_ADD=5'b00011 … OP_NOT=5'b10010);
  - the encoder bit-index constants (SEL_HI=16 … SEL_C=23).
- One sub-module, datapath_alu: the combinational 64-bit-result ALU, with inputs A, B, op and AND, and output C.
- Registers, MDR mux, encoder and bus mux stay in the top level.

Test Plan:
- Reset: assert clear with all strobes active for one edge -> every register reads 0 and the bus reads 0 with no strobe set.
- MDR load: Read=1, MDRin=1, Mdatain=0x22; next cycle MDRout=1, R2in=1 -> R2=0x22.
- Mul: with R2=0x22 and R6=0x24, run R2out+Yin, then R6out+Zlowin with operation=10000, then Zlowout+LOin, then Zhighout+HIin -> LO=0x4C8, HI=0.
- Signed ops: Y=0xFFFFFFFE (-2), bus=3.
  - mul -> ZHigh=0xFFFFFFFF, ZLow=0xFFFFFFFA.
  - With the macro defined, Y=7, bus=2, div -> ZLow=3, ZHigh=1.
  - Y=7, bus=0, div -> Z = 0.
- PC: PC=0xFFFFFFFF, IncPC=1 -> PC=0. PCin=1 with IncPC=1 and bus=0x10 -> PC=0x10.
- Encoder: PCout=1 and MDRout=1 together -> encoder_input bits 20 and 21 set, bus = MDR (highest index wins). R3out alone -> bus = 0.
